// File: rtl/stream_unpad.sv
// -----------------------------------------------------------------------------
// stream_unpad
//
// Purpose:
//   Streaming crop stage. It takes a zero-padded frame of DATA_W-bit words
//   (fp32 feature values) in raster order and removes a PAD-wide border on
//   every side. Only interior words are forwarded, and the last interior word
//   of each frame is flagged with m_last. This undoes the padding stage on the
//   super-resolution datapath. It sits after the convolution stages and ahead
//   of output packing or write-back.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous assert, active-low reset
//   s_valid    in   1       input word valid
//   s_ready    out  1       block can accept an input word
//   s_data     in   DATA_W  input (padded) word
//   s_last     in   1       producer end-of-frame marker, expected on the
//                           padded word (IN_H-1, IN_W-1)
//   m_valid    out  1       output word valid
//   m_ready    in   1       downstream accepts the output word
//   m_data     out  DATA_W  interior word
//   m_last     out  1       last interior word of the frame
//   frame_err  out  1       one-cycle pulse on an s_last / position mismatch
//
// Buffering is a single output register. The input side is ready whenever
// that register is empty or is being drained in the same cycle. This gives a
// full 1 word/cycle rate with no skid buffer.
// -----------------------------------------------------------------------------
module stream_unpad #(
   parameter int DATA_W = 32,
   parameter int IN_W   = 5,
   parameter int IN_H   = 5,
   parameter int PAD    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              frame_err
);

   // Counter widths. They are at least one bit, so a 1-wide or 1-high frame
   // still elaborates.
   localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;

   // Position constants.
   localparam logic [CW-1:0] C_COL_MAX = CW'(IN_W - 1);
   localparam logic [RW-1:0] C_ROW_MAX = RW'(IN_H - 1);
   localparam logic [CW-1:0] C_COL_LO  = CW'(PAD);
   localparam logic [RW-1:0] C_ROW_LO  = RW'(PAD);
   localparam logic [CW-1:0] C_COL_HI  = CW'(IN_W - PAD - 1);
   localparam logic [RW-1:0] C_ROW_HI  = RW'(IN_H - PAD - 1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic              r_m_valid;
   logic [DATA_W-1:0] r_m_data;
   logic              r_m_last;
   logic              r_frame_err;

   // Next-state values.
   logic [CW-1:0]     w_col_next;
   logic [RW-1:0]     w_row_next;
   logic              w_m_valid_next;
   logic [DATA_W-1:0] w_m_data_next;
   logic              w_m_last_next;
   logic              w_frame_err_next;

   // Decode of the current padded position.
   logic w_in_beat;
   logic w_out_beat;
   logic w_col_keep;
   logic w_row_keep;
   logic w_keep;
   logic w_sync_end;
   logic w_last_interior;

   // -------------------------------------------------------------------------
   // Handshake
   // -------------------------------------------------------------------------
   // The output register is the only storage. A new word may enter when that
   // register is empty or is being emptied on this edge.
   assign s_ready    = !r_m_valid || m_ready;
   assign w_in_beat  = s_valid && s_ready;
   assign w_out_beat = r_m_valid && m_ready;

   // -------------------------------------------------------------------------
   // Interior window decode
   // -------------------------------------------------------------------------
   // With PAD=0 the window covers the whole frame. The comparisons are
   // dropped because the lower bound is trivially true for unsigned counters.
   generate
      if (PAD == 0) begin : g_no_pad
         assign w_col_keep = 1'b1;
         assign w_row_keep = 1'b1;
      end else begin : g_pad
         assign w_col_keep = (r_col >= C_COL_LO) && (r_col <= C_COL_HI);
         assign w_row_keep = (r_row >= C_ROW_LO) && (r_row <= C_ROW_HI);
      end
   endgenerate

   assign w_keep          = w_col_keep && w_row_keep;
   assign w_sync_end      = (r_col == C_COL_MAX) && (r_row == C_ROW_MAX);
   assign w_last_interior = (r_col == C_COL_HI) && (r_row == C_ROW_HI);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_col_next       = r_col;
      w_row_next       = r_row;
      w_m_valid_next   = r_m_valid;
      w_m_data_next    = r_m_data;
      w_m_last_next    = r_m_last;
      w_frame_err_next = 1'b0;

      // A drained word frees the register. A kept word loaded on the same
      // edge overrides this below, so there is no bubble.
      if (w_out_beat) begin
         w_m_valid_next = 1'b0;
      end

      if (w_in_beat) begin
         // The keep decision always uses the position before any resync.
         if (w_keep) begin
            w_m_valid_next = 1'b1;
            w_m_data_next  = s_data;
            w_m_last_next  = w_last_interior;
         end

         // Flag an early s_last, and also a missing s_last at the end of the
         // frame.
         w_frame_err_next = s_last ^ w_sync_end;

         if (s_last && !w_sync_end) begin
            // Early end-of-frame from the producer. Realign to its framing,
            // so the next word is treated as padded position (0,0).
            w_col_next = '0;
            w_row_next = '0;
         end else if (r_col == C_COL_MAX) begin
            w_col_next = '0;
            if (r_row == C_ROW_MAX) begin
               w_row_next = '0;
            end else begin
               w_row_next = r_row + 1'b1;
            end
         end else begin
            w_col_next = r_col + 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col       <= '0;
         r_row       <= '0;
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_m_last    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_col       <= w_col_next;
         r_row       <= w_row_next;
         r_m_valid   <= w_m_valid_next;
         r_m_data    <= w_m_data_next;
         r_m_last    <= w_m_last_next;
         r_frame_err <= w_frame_err_next;
      end
   end

   assign m_valid   = r_m_valid;
   assign m_data    = r_m_data;
   assign m_last    = r_m_last;
   assign frame_err = r_frame_err;

endmodule

// File: doc/stream_unpad.md
Name: stream_unpad

Overview:
- Streaming crop block; the inverse of the zero-padding stage on the super-resolution datapath.
- Accepts a padded frame of DATA_W-bit words (fp32 feature values) in raster order over a valid/ready stream.
- Discards the PAD-wide border and forwards only interior words, marking the last interior word of each frame.
- Sits after convolution stages, before output packing or write-back.

Parameters:
- DATA_W, 32, word width (one fp32 value).
- IN_W, 5, padded frame width in words.
- IN_H, 5, padded frame height in rows.
- PAD, 1, border width removed on every side; 0 <= 2*PAD < IN_W and 2*PAD < IN_H.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept an input word.
- s_data  in  DATA_W  input word.
- s_last  in  1  producer end-of-frame marker, expected on padded word (IN_H-1, IN_W-1).
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  DATA_W  interior word.
- m_last  out  1  last interior word of the frame.
- frame_err  out  1  one-cycle pulse on an s_last/position mismatch.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_last=0, frame_err=0, col=0, row=0. s_ready=1 once rst_n is high.
- An input beat is s_valid && s_ready. An output beat is m_valid && m_ready.
- s_ready = !m_valid || m_ready (combinational). The output register holds exactly one word; there is no other buffering.
- On each input beat, keep the word when PAD <= col < IN_W-PAD and PAD <= row < IN_H-PAD.
  - A kept word is registered next cycle: m_data=s_data, m_valid=1, m_last = (col==IN_W-PAD-1 && row==IN_H-PAD-1).
  - A border word is consumed and dropped. If no new kept word is loaded in that cycle, m_valid clears on the output beat.
- Latency: 1 cycle from a kept input beat to m_valid. Full throughput of 1 word/cycle with m_ready held high.
- Position counters advance on every input beat.
  - col increments, wrapping to 0 at IN_W-1; row then increments.
  - At (IN_H-1, IN_W-1) both counters return to 0.
- Backpressure: while m_valid && !m_ready, s_ready=0. m_data and m_last hold stable and the counters freeze.
- Frame check on each input beat; sync-end = (row==IN_H-1 && col==IN_W-1).
  - s_last=1 and not at sync-end: frame_err=1 next cycle, and both counters reset to 0 (resync). The kept/drop decision for this beat still uses the pre-reset position.
  - s_last=0 at sync-end: frame_err=1 next cycle; counters wrap normally.
  - Otherwise frame_err=0.
- Simultaneous output beat and kept input beat: the new word replaces the old one in the same edge, with no bubble.
- Reset mid-frame: any pending output word is discarded and counters return to 0. The next accepted word is treated as padded position (0,0).
- PAD=0: pass-through. Every word is forwarded, and m_last is set on padded word (IN_H-1, IN_W-1).

Test Plan:
- 5x5 frame, words 0..24, s_last on 24, m_ready=1 -> m_data sequence 6,7,8,11,12,13,16,17,18. m_last only on 18. frame_err stays 0. Exactly 9 output beats, each 1 cycle after its input beat.
- Same frame with m_ready toggling 1,0,0,1 repeating -> identical output sequence. No word lost or duplicated. m_data stable while stalled. s_ready low exactly when m_valid && !m_ready.
- Two back-to-back frames (0..24, then 100..124) with s_valid constant -> second frame yields 106,107,108,111,112,113,116,117,118. m_last on 18 and on 118.
- s_last asserted on word 12 (position (2,2)) -> 12 is still output. frame_err pulses once. The following words 200..224 are treated as a new frame: output 206..208, 211..213, 216..218.
- Frame 0..24 with s_last missing on 24 -> frame_err pulses once the cycle after word 24. Outputs unchanged.
- rst_n pulsed low for 2 cycles after word 13 -> m_valid drops immediately (asynchronously). A fresh frame 0..24 afterwards produces the normal 9-word output.
